// File: rtl/apb_sysctl_pkg.sv
// Shared register map, CTRL field layout and address decode for the APB system controller/timer.
package apb_sysctl_pkg;

    localparam logic [11:0] OFF_VERSION  = 12'h000;
    localparam logic [11:0] OFF_CTRL     = 12'h004;
    localparam logic [11:0] OFF_STATUS   = 12'h008;
    localparam logic [11:0] OFF_GPIO_OUT = 12'h010;
    localparam logic [11:0] OFF_GPIO_IN  = 12'h014;
    localparam logic [11:0] OFF_IRQ_PEND = 12'h018;
    localparam logic [11:0] OFF_IRQ_EN   = 12'h01C;
    localparam logic [11:0] OFF_MTIME_LO = 12'h020;
    localparam logic [11:0] OFF_MTIME_HI = 12'h024;
    localparam logic [11:0] CMP_BASE     = 12'h100;
    localparam int          CMP_STRIDE   = 8;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_PRESC_LSB    = 8;
    localparam int STATUS_DONE_BIT   = 16;
    localparam int STATUS_ERROR_BIT  = 17;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [3:0] {
        REG_VERSION, REG_CTRL, REG_STATUS, REG_GPIO_OUT, REG_GPIO_IN,
        REG_IRQ_PEND, REG_IRQ_EN, REG_MTIME_LO, REG_MTIME_HI, REG_CMP, REG_NONE
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e   sel;
        logic [2:0] chan;
        logic       hi;
    } reg_dec_t;

    // addr must already have its byte-lane bits cleared.
    function automatic reg_dec_t decode_addr(input logic [11:0] addr, input int ncmp);
        reg_dec_t d;
        d.sel  = REG_NONE;
        d.chan = addr[5:3];
        d.hi   = addr[2];
        case (addr)
            OFF_VERSION:  d.sel = REG_VERSION;
            OFF_CTRL:     d.sel = REG_CTRL;
            OFF_STATUS:   d.sel = REG_STATUS;
            OFF_GPIO_OUT: d.sel = REG_GPIO_OUT;
            OFF_GPIO_IN:  d.sel = REG_GPIO_IN;
            OFF_IRQ_PEND: d.sel = REG_IRQ_PEND;
            OFF_IRQ_EN:   d.sel = REG_IRQ_EN;
            OFF_MTIME_LO: d.sel = REG_MTIME_LO;
            OFF_MTIME_HI: d.sel = REG_MTIME_HI;
            default: begin
                if (addr[11:8] == CMP_BASE[11:8] && 32'(addr[7:3]) < ncmp)
                    d.sel = REG_CMP;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/apb_sysctl_timer_if.sv
// APB bus bundle for the system controller; names are from the slave's point of view.
interface apb_sysctl_timer_if;
    // Setup phase: psel=1, penable=0. Access phase: psel=1, penable=1. The slave
    // always answers pready=1, so every transfer is exactly one setup plus one access cycle.
    logic        i_psel;
    logic        i_penable;
    logic [11:0] i_paddr;
    logic        i_pwrite;
    logic [31:0] i_pwdata;
    logic [31:0] o_prdata;
    logic        o_pready;
    logic        o_pslverr;

    modport master (
        output i_psel, i_penable, i_paddr, i_pwrite, i_pwdata,
        input  o_prdata, o_pready, o_pslverr
    );

    modport slave (
        input  i_psel, i_penable, i_paddr, i_pwrite, i_pwdata,
        output o_prdata, o_pready, o_pslverr
    );
endinterface

// File: rtl/apb_sysctl_timer_cmp_chan.sv
// One 64-bit compare channel: mtimecmp register, sticky pending bit and registered irq line.
module timer_cmp_chan
    import apb_sysctl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    input  logic        w1c,
    input  logic        irq_en,
    input  logic [63:0] mtime,
    output logic [63:0] cmp,
    output logic        pend,
    output logic        irq
);
    logic [63:0] cmp_q, cmp_d;
    logic        pend_q, pend_d;
    logic        irq_q, irq_d;
    logic        hit;

    always_comb begin
        cmp_d = cmp_q;
        if (wr_lo) cmp_d[31:0]  = wdata;
        if (wr_hi) cmp_d[63:32] = wdata;

        hit = (mtime >= cmp_q);

        // Reprogramming the compare or a W1C beats a simultaneous hit; a persisting hit re-pends next cycle.
        pend_d = pend_q;
        if (wr_lo || wr_hi || w1c) pend_d = 1'b0;
        else if (hit)              pend_d = 1'b1;

        irq_d = pend_q & irq_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_q  <= MTIMECMP_RST;
            pend_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            cmp_q  <= cmp_d;
            pend_q <= pend_d;
            irq_q  <= irq_d;
        end
    end

    assign cmp  = cmp_q;
    assign pend = pend_q;
    assign irq  = irq_q;
endmodule

// File: rtl/apb_sysctl_timer.sv
// APB system controller: version/status, GPIO, prescaled 64-bit mtime and NCMP compare channels.
module apb_sysctl_timer
    import apb_sysctl_pkg::*;
#(
    parameter int          NCMP    = 2,
    parameter int          GPIO_W  = 4,
    parameter int          PRESC_W = 8,
    parameter logic [31:0] VERSION = 32'h0001_0000
) (
    input  logic                clk,
    input  logic                rst,
    apb_sysctl_timer_if.slave   apb,
    input  logic                i_ram_init_done,
    input  logic                i_ram_init_error,
    input  logic [GPIO_W-1:0]   i_gpio,
    output logic [GPIO_W-1:0]   o_gpio,
    output logic [NCMP-1:0]     o_timer_irq
);
    logic [31:0]        prdata_q, prdata_d;
    logic               pslverr_q, pslverr_d;
    logic               en_q, en_d;
    logic [PRESC_W-1:0] presc_q, presc_d, cnt_q, cnt_d;
    logic [63:0]        mtime_q, mtime_d;
    logic [GPIO_W-1:0]  gpio_q, gpio_d, sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NCMP-1:0]    irq_en_q, irq_en_d;

    logic               setup, wr, tick;
    reg_dec_t           dec;
    logic [31:0]        rd_data;
    logic [NCMP-1:0]    cmp_wr_lo, cmp_wr_hi, w1c, pend;
    logic [63:0]        cmp_val [NCMP];
    logic               unused_paddr_bits;

    assign unused_paddr_bits = ^apb.i_paddr[1:0];
    assign setup = apb.i_psel & ~apb.i_penable;
    assign wr    = apb.i_psel & apb.i_penable & apb.i_pwrite;
    assign dec   = decode_addr({apb.i_paddr[11:2], 2'b00}, NCMP);

    always_comb begin
        rd_data = '0;
        case (dec.sel)
            REG_VERSION:  rd_data = VERSION;
            REG_CTRL: begin
                rd_data[CTRL_EN_BIT]                 = en_q;
                rd_data[CTRL_PRESC_LSB +: PRESC_W]   = presc_q;
            end
            REG_STATUS: begin
                rd_data[STATUS_DONE_BIT]  = i_ram_init_done;
                rd_data[STATUS_ERROR_BIT] = i_ram_init_error;
            end
            REG_GPIO_OUT: rd_data[GPIO_W-1:0] = gpio_q;
            REG_GPIO_IN:  rd_data[GPIO_W-1:0] = sync2_q;
            REG_IRQ_PEND: rd_data[NCMP-1:0]   = pend;
            REG_IRQ_EN:   rd_data[NCMP-1:0]   = irq_en_q;
            REG_MTIME_LO: rd_data = mtime_q[31:0];
            REG_MTIME_HI: rd_data = mtime_q[63:32];
            default: begin
                for (int i = 0; i < NCMP; i++)
                    if (dec.sel == REG_CMP && dec.chan == 3'(i))
                        rd_data = dec.hi ? cmp_val[i][63:32] : cmp_val[i][31:0];
            end
        endcase
    end

    always_comb begin
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        if (setup) begin
            pslverr_d = (dec.sel == REG_NONE);
            if (!apb.i_pwrite) prdata_d = rd_data;
        end

        en_d     = en_q;
        presc_d  = presc_q;
        gpio_d   = gpio_q;
        irq_en_d = irq_en_q;
        if (wr && dec.sel == REG_CTRL) begin
            en_d    = apb.i_pwdata[CTRL_EN_BIT];
            presc_d = apb.i_pwdata[CTRL_PRESC_LSB +: PRESC_W];
        end
        if (wr && dec.sel == REG_GPIO_OUT) gpio_d   = apb.i_pwdata[GPIO_W-1:0];
        if (wr && dec.sel == REG_IRQ_EN)   irq_en_d = apb.i_pwdata[NCMP-1:0];

        // The divider restarts from 0 whenever CTRL is written so a new presc takes effect cleanly.
        tick  = en_q && (cnt_q == presc_q);
        cnt_d = cnt_q;
        if (wr && dec.sel == REG_CTRL) cnt_d = '0;
        else if (en_q)                 cnt_d = tick ? '0 : cnt_q + PRESC_W'(1);

        mtime_d = mtime_q;
        if (wr && (dec.sel == REG_MTIME_LO || dec.sel == REG_MTIME_HI)) begin
            if (dec.sel == REG_MTIME_LO) mtime_d[31:0]  = apb.i_pwdata;
            else                         mtime_d[63:32] = apb.i_pwdata;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        sync1_d = i_gpio;
        sync2_d = sync1_q;

        cmp_wr_lo = '0;
        cmp_wr_hi = '0;
        for (int i = 0; i < NCMP; i++) begin
            if (wr && dec.sel == REG_CMP && dec.chan == 3'(i)) begin
                cmp_wr_lo[i] = ~dec.hi;
                cmp_wr_hi[i] = dec.hi;
            end
        end
        w1c = (wr && dec.sel == REG_IRQ_PEND) ? apb.i_pwdata[NCMP-1:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            en_q      <= 1'b1;
            presc_q   <= '0;
            cnt_q     <= '0;
            mtime_q   <= '0;
            gpio_q    <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            irq_en_q  <= '0;
        end else begin
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            en_q      <= en_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            mtime_q   <= mtime_d;
            gpio_q    <= gpio_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            irq_en_q  <= irq_en_d;
        end
    end

    for (genvar i = 0; i < NCMP; i++) begin : g_chan
        timer_cmp_chan u_chan (
            .clk    (clk),
            .rst    (rst),
            .wr_lo  (cmp_wr_lo[i]),
            .wr_hi  (cmp_wr_hi[i]),
            .wdata  (apb.i_pwdata),
            .w1c    (w1c[i]),
            .irq_en (irq_en_q[i]),
            .mtime  (mtime_q),
            .cmp    (cmp_val[i]),
            .pend   (pend[i]),
            .irq    (o_timer_irq[i])
        );
    end

    assign apb.o_prdata  = prdata_q;
    assign apb.o_pready  = 1'b1;
    assign apb.o_pslverr = pslverr_q;
    assign o_gpio        = gpio_q;
endmodule

// File: tb/tb_apb_sysctl_timer.sv
// Bench for apb_sysctl_timer: reset-state vector table, randomized register traffic and timer corner sequences.
module tb_apb_sysctl_timer;
    logic       clk = 1'b0;
    logic       rst;
    logic       ram_done, ram_err;
    logic [3:0] gpio_in, gpio_out;
    logic [1:0] irq;

    always #5 clk = ~clk;

    apb_sysctl_timer_if bus ();

    apb_sysctl_timer #(.NCMP(2), .GPIO_W(4), .PRESC_W(8), .VERSION(32'h0001_0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .apb              (bus),
        .i_ram_init_done  (ram_done),
        .i_ram_init_error (ram_err),
        .i_gpio           (gpio_in),
        .o_gpio           (gpio_out),
        .o_timer_irq      (irq)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [11:0] addr;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;
    vec_t vecs[14];

    int addrs[14] = '{'h000, 'h004, 'h008, 'h010, 'h01C, 'h100, 'h104, 'h108, 'h10C,
                      'h00C, 'h0F0, 'h110, 'h028, 'hFFC};
    logic [31:0] shadow [0:1023];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.i_psel = 1'b0;
        bus.i_penable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic e);
        @(negedge clk);
        bus.i_psel = 1'b1; bus.i_penable = 1'b0; bus.i_pwrite = 1'b1;
        bus.i_paddr = a; bus.i_pwdata = d;
        @(negedge clk);
        bus.i_penable = 1'b1;
        @(negedge clk);
        e = bus.o_pslverr;
        bus.i_psel = 1'b0; bus.i_penable = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e);
        @(negedge clk);
        bus.i_psel = 1'b1; bus.i_penable = 1'b0; bus.i_pwrite = 1'b0; bus.i_paddr = a;
        @(negedge clk);
        bus.i_penable = 1'b1;
        @(negedge clk);
        d = bus.o_prdata; e = bus.o_pslverr;
        bus.i_psel = 1'b0; bus.i_penable = 1'b0;
    endtask

    function automatic logic [31:0] rw_mask(input int a);
        case (a)
            'h004:                     return 32'h0000_FF01;
            'h010:                     return 32'h0000_000F;
            'h01C:                     return 32'h0000_0003;
            'h100, 'h104, 'h108, 'h10C: return 32'hFFFF_FFFF;
            default:                   return 32'h0;
        endcase
    endfunction

    function automatic logic is_mapped(input int a);
        return (a == 'h000 || a == 'h008 || rw_mask(a) != 0);
    endfunction

    function automatic logic [31:0] ref_read(input int a);
        if (a == 'h000) return 32'h0001_0000;
        if (a == 'h008) return {14'b0, ram_err, ram_done, 16'b0};
        if (!is_mapped(a)) return 32'h0;
        return shadow[a >> 2];
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, d2;
        logic        e;

        rst = 1'b1; ram_done = 1'b1; ram_err = 1'b0; gpio_in = 4'h0;
        bus.i_psel = 0; bus.i_penable = 0; bus.i_pwrite = 0; bus.i_paddr = '0; bus.i_pwdata = '0;

        // ---- reset state through the vector table
        vecs[0]  = '{12'h000, 32'h0001_0000, 1'b0};
        vecs[1]  = '{12'h004, 32'h0000_0001, 1'b0};
        vecs[2]  = '{12'h008, 32'h0001_0000, 1'b0};
        vecs[3]  = '{12'h010, 32'h0000_0000, 1'b0};
        vecs[4]  = '{12'h014, 32'h0000_0000, 1'b0};
        vecs[5]  = '{12'h018, 32'h0000_0000, 1'b0};
        vecs[6]  = '{12'h01C, 32'h0000_0000, 1'b0};
        vecs[7]  = '{12'h024, 32'h0000_0000, 1'b0};
        vecs[8]  = '{12'h100, 32'hFFFF_FFFF, 1'b0};
        vecs[9]  = '{12'h10F, 32'hFFFF_FFFF, 1'b0};
        vecs[10] = '{12'h0F0, 32'h0000_0000, 1'b1};
        vecs[11] = '{12'h110, 32'h0000_0000, 1'b1};
        vecs[12] = '{12'h00C, 32'h0000_0000, 1'b1};
        vecs[13] = '{12'hFFC, 32'h0000_0000, 1'b1};

        do_reset();
        check("rst_gpio_out", gpio_out, 4'h0);
        check("rst_irq", irq, 2'b00);
        check("rst_pslverr", bus.o_pslverr, 1'b0);
        check("rst_prdata", bus.o_prdata, 32'h0);
        check("pready", bus.o_pready, 1'b1);
        for (int i = 0; i < 14; i++) begin
            apb_read(vecs[i].addr, d, e);
            check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
            check($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
        end

        // ---- randomized register traffic against a shadow-register model
        do_reset();
        for (int i = 0; i < 1024; i++) shadow[i] = 32'h0;
        shadow['h004 >> 2] = 32'h1;
        for (int i = 'h100; i <= 'h10C; i += 4) shadow[i >> 2] = 32'hFFFF_FFFF;
        for (int k = 0; k < 200; k++) begin
            int          a;
            logic [11:0] pa;
            logic [31:0] wd;
            a  = addrs[$urandom_range(0, 13)];
            pa = 12'(a) | 12'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom;
                apb_write(pa, wd, e);
                check("rand_wr_err", e, !is_mapped(a));
                if (rw_mask(a) != 0) shadow[a >> 2] = wd & rw_mask(a);
                if (a == 'h010) check("rand_gpio_pin", gpio_out, shadow['h010 >> 2][3:0]);
            end else begin
                exp_q.push_back(ref_read(a));
                apb_read(pa, d, e);
                check("rand_rd_err", e, !is_mapped(a));
                check("rand_rd_data", d, exp_q.pop_front());
            end
        end

        // ---- prescaler: presc=3 gives one mtime step per 4 cycles; en=0 freezes
        do_reset();
        apb_write(12'h004, 32'h0000_0301, e);
        apb_read(12'h020, d, e);
        repeat (37) @(negedge clk);
        apb_read(12'h020, d2, e);
        check("presc_delta", d2 - d, 32'd10);
        apb_write(12'h004, 32'h0000_0000, e);
        apb_read(12'h020, d, e);
        repeat (10) @(negedge clk);
        apb_read(12'h020, d2, e);
        check("freeze_delta", d2 - d, 32'd0);

        // ---- compare latency, W1C re-pend, reprogram drops irq
        do_reset();
        apb_write(12'h10C, 32'h0, e);
        apb_write(12'h108, 32'd100, e);
        apb_write(12'h01C, 32'h2, e);
        apb_write(12'h020, 32'd90, e);
        repeat (11) @(negedge clk);
        check("irq1_before_12", irq[1], 1'b0);
        @(negedge clk);
        check("irq1_at_12", irq[1], 1'b1);
        check("irq0_quiet", irq[0], 1'b0);
        apb_write(12'h018, 32'h2, e);
        @(negedge clk);
        check("w1c_irq_low", irq[1], 1'b0);
        @(negedge clk);
        check("w1c_repend_irq", irq[1], 1'b1);
        apb_write(12'h108, 32'd1000, e);
        @(negedge clk);
        begin
            int highs = 0;
            for (int c = 0; c < 20; c++) begin
                if (irq[1] !== 1'b0) highs++;
                @(negedge clk);
            end
            check("reprog_irq_low_cycles", highs, 0);
        end
        apb_read(12'h018, d, e);
        check("reprog_pend", d, 32'h0);

        // ---- mtime wrap with mtimecmp[0]=0
        do_reset();
        apb_write(12'h104, 32'h0, e);
        apb_write(12'h100, 32'h0, e);
        apb_write(12'h024, 32'hFFFF_FFFF, e);
        apb_write(12'h020, 32'hFFFF_FFFE, e);
        repeat (3) @(negedge clk);
        apb_read(12'h024, d, e);
        check("wrap_hi", d, 32'h0);
        apb_read(12'h020, d, e);
        check("wrap_lo_small", (d < 32'd16), 1'b1);
        apb_read(12'h018, d, e);
        check("wrap_pend0", d[0], 1'b1);

        // ---- GPIO out and synchronised in
        do_reset();
        apb_write(12'h010, 32'hF, e);
        check("gpio_out_F", gpio_out, 4'hF);
        @(negedge clk);
        gpio_in = 4'hA;
        repeat (2) @(negedge clk);
        apb_read(12'h014, d, e);
        check("gpio_in_A", d, 32'hA);

        // ---- reset during the access phase of a GPIO_OUT write
        apb_write(12'h104, 32'h0, e);
        apb_write(12'h100, 32'h0, e);
        apb_write(12'h01C, 32'h1, e);
        repeat (3) @(negedge clk);
        check("pre_rst_irq0", irq[0], 1'b1);
        @(negedge clk);
        bus.i_psel = 1'b1; bus.i_penable = 1'b0; bus.i_pwrite = 1'b1;
        bus.i_paddr = 12'h010; bus.i_pwdata = 32'h5;
        @(negedge clk);
        bus.i_penable = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_gpio", gpio_out, 4'h0);
        check("midrst_irq", irq, 2'b00);
        check("midrst_pslverr", bus.o_pslverr, 1'b0);
        bus.i_psel = 1'b0; bus.i_penable = 1'b0;
        rst = 1'b0;
        apb_read(12'h010, d, e);
        check("midrst_no_commit", d, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_sysctl_timer.md
Name: apb_sysctl_timer

Overview:
- Parametrised successor to the single-timer APB system controller.
- Provides:
  - version/status registers
  - GPIO out with a synchronised GPIO in
  - a prescaled 64-bit mtime
  - NCMP independent 64-bit compare channels with a pending/enable interrupt model
- APB slave on the peripheral bus. Zero-wait access phase. Errors on unmapped addresses.
- Per-channel interrupt lines go to the core/interrupt controller.

Parameters:
- NCMP, 2, number of compare channels (1..8).
- GPIO_W, 4, GPIO output and input width (1..32).
- PRESC_W, 8, width of the prescaler divisor field.
- VERSION, 32'h0001_0000, value returned by the VERSION register.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_psel  in  1  APB select
- i_penable  in  1  APB enable
- i_paddr  in  12  APB byte address
- i_pwrite  in  1  APB write
- i_pwdata  in  32  APB write data
- o_prdata  out  32  APB read data
- o_pready  out  1  APB ready
- o_pslverr  out  1  APB error
- i_ram_init_done  in  1  RAM init status
- i_ram_init_error  in  1  RAM init status
- i_gpio  in  GPIO_W  asynchronous GPIO inputs
- o_gpio  out  GPIO_W  GPIO outputs
- o_timer_irq  out  NCMP  per-channel interrupt, level

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All state resets on a clk edge with rst=1.
- Reset values:
  - o_gpio=0, o_timer_irq=0, o_prdata=0, o_pslverr=0
  - mtime=0, every mtimecmp=64'hFFFF_FFFF_FFFF_FFFF
  - IRQ_PEND=0, IRQ_EN=0
  - CTRL.en=1, CTRL.presc=0
  - prescaler count=0, gpio sync flops=0
- APB protocol:
  - o_pready=1 constantly.
  - Read data is registered in the setup phase (psel & ~penable & ~pwrite) and held stable through the access phase.
  - Writes commit on psel & penable & pwrite.
  - o_pslverr is registered in the setup phase and is 1 for an unmapped offset, reads and writes alike. Unmapped reads return 0. Unmapped writes have no effect.
- Register map (byte offsets, word-aligned; paddr[1:0] ignored):
  - 0x000 VERSION (RO)
  - 0x004 CTRL: [0] en, [8+:PRESC_W] presc
  - 0x008 STATUS (RO): [17] ram_init_error, [16] ram_init_done
  - 0x010 GPIO_OUT (RW)
  - 0x014 GPIO_IN (RO): 2-flop synchronised i_gpio
  - 0x018 IRQ_PEND: W1C
  - 0x01C IRQ_EN (RW)
  - 0x020 MTIME_LO, 0x024 MTIME_HI (RW)
  - 0x100+8*i MTIMECMP_LO[i], 0x104+8*i MTIMECMP_HI[i], for i < NCMP
  - Unused upper bits read 0.
- Prescaler and mtime:
  - When en=1, the prescaler counts 0..presc.
  - On the cycle the count equals presc, the count returns to 0 and mtime increments by 1. With presc=0, mtime increments every cycle.
  - mtime wraps at 2^64-1 → 0.
  - en=0 freezes both the count and mtime.
  - A CTRL write resets the count to 0.
- mtime write priority: a write to MTIME_LO/HI replaces that half that cycle and suppresses the increment that cycle.
- Compare channels, each cycle per channel i:
  - hit_i = (mtime >= mtimecmp[i]), unsigned 64-bit compare on the registered values.
  - If hit_i, pend[i] <= 1 (sticky).
  - A W1C with bit i set clears pend[i]. If hit_i is still true, pend[i] re-sets on the following cycle.
  - A write to either half of mtimecmp[i] clears pend[i] that cycle, with priority over hit_i.
  - o_timer_irq[i] is registered: pend[i] & en_irq[i], one cycle after pend.
- Latency:
  - mtime reaching mtimecmp → pend set at the next edge → o_timer_irq at the edge after that.
  - IRQ_EN write → o_timer_irq updates one cycle later.
- Simultaneous events (same cycle):
  - W1C of bit i and hit_i: the clear wins for that cycle; pend re-sets next cycle.
  - mtime wrap to 0 while mtimecmp=0: hit stays true.
- Reset mid-transfer: the transfer is dropped, nothing is committed, and outputs return to reset values.

Decomposition:
- Package apb_sysctl_pkg holds:
  - register offset localparams (VERSION, CTRL, STATUS, GPIO_OUT, GPIO_IN, IRQ_PEND, IRQ_EN, MTIME_LO/HI, CMP_BASE=0x100, CMP_STRIDE=8)
  - the CTRL field positions
  - the reset value of mtimecmp
- Sub-module timer_cmp_chan is instantiated NCMP times. It holds the 64-bit mtimecmp, compare, pending and irq flop, and takes a decoded write strobe, W1C bit, enable bit and mtime.
- The top holds the APB decode, read mux, prescaler, mtime and GPIO.

Test Plan:
- Reset then read all registers.
  - VERSION=32'h0001_0000, CTRL=0x1, MTIMECMP_LO[0]=0xFFFF_FFFF.
  - Read 0x0F0 → prdata=0, pslverr=1.
- Set CTRL presc=3, en=1, then read MTIME_LO twice, 40 cycles apart → values differ by 10±1.
- Set mtimecmp[1]=100, IRQ_EN=0b10, mtime=90, presc=0.
  - o_timer_irq[1] rises exactly 12 cycles after the MTIME_LO write commits; o_timer_irq[0] stays 0.
  - W1C bit 1 → pend re-sets next cycle.
  - Then write mtimecmp[1]=1000 → irq drops and stays low.
- Write MTIME_HI=0xFFFF_FFFF, MTIME_LO=0xFFFF_FFFE with en=1, presc=0 → after 2 cycles mtime wraps to 0; a channel with mtimecmp=0 keeps pend=1.
- Write GPIO_OUT=0xF, GPIO_W=4 → o_gpio=4'hF next cycle. Toggle i_gpio → GPIO_IN reflects it after 2 cycles plus the read.
- Assert rst mid access phase of a GPIO_OUT write → o_gpio=0, no commit, o_timer_irq=0.
